// File: rtl/arm_cpu_pkg.sv
// arm_cpu_pkg: shared types and constants for the arm_cpu execution core.
//   opcode_e - data-processing opcode field [24:21]
//   shift_e  - operand2 shift type field [6:5]
//   state_e  - run sequencer states
//   FLAG_*   - NZCV bit positions inside status_out
package arm_cpu_pkg;

    typedef enum logic [3:0] {
        OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3,
        OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7,
        OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB,
        OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00, SH_LSR = 2'b01, SH_ASR = 2'b10, SH_ROR = 2'b11
    } shift_e;

    typedef enum logic [1:0] {
        ST_LOAD = 2'b00, ST_EXEC = 2'b01, ST_WB = 2'b10, ST_DONE = 2'b11
    } state_e;

    localparam int unsigned FLAG_N = 31;
    localparam int unsigned FLAG_Z = 30;
    localparam int unsigned FLAG_C = 29;
    localparam int unsigned FLAG_V = 28;

    // Rotate right; amount 0 returns the value unchanged.
    function automatic logic [31:0] ror32(input logic [31:0] v, input logic [4:0] amt);
        ror32 = (v >> amt) | (v << (6'd32 - {1'b0, amt}));
    endfunction

    // Compare ops update flags only and never write Rd.
    function automatic logic is_compare(input opcode_e op);
        is_compare = (op == OP_TST) || (op == OP_TEQ) || (op == OP_CMP) || (op == OP_CMN);
    endfunction

endpackage

// File: rtl/arm_cpu_shifter.sv
// arm_shifter: combinational operand2 barrel shifter/rotator.
//   imm    in  1   I bit; 1 selects rotated 8-bit immediate
//   op2    in  12  operand2 field of the instruction
//   rm     in  32  Rm value
//   rs     in  8   low byte of Rs (register-specified shift amount)
//   result out 32  shifted operand2
module arm_shifter
    import arm_cpu_pkg::*;
(
    input  logic        imm,
    input  logic [11:0] op2,
    input  logic [31:0] rm,
    input  logic [7:0]  rs,
    output logic [31:0] result
);

    logic [7:0] amt;
    logic       big;
    shift_e     sh;

    always_comb begin
        result = rm;
        amt    = '0;
        big    = 1'b0;
        sh     = shift_e'(op2[6:5]);
        if (imm) begin
            result = ror32({24'b0, op2[7:0]}, {op2[11:8], 1'b0});
        end else begin
            amt = op2[4] ? rs : {3'b0, op2[11:7]};
            big = (amt[7:5] != 3'b0);
            if (amt != 8'd0) begin
                case (sh)
                    SH_LSL: result = big ? '0 : (rm << amt[4:0]);
                    SH_LSR: result = big ? '0 : (rm >> amt[4:0]);
                    SH_ASR: result = big ? {32{rm[31]}} : 32'($signed(rm) >>> amt[4:0]);
                    SH_ROR: result = ror32(rm, amt[4:0]);
                endcase
            end
        end
    end

endmodule

// File: rtl/arm_cpu.sv
// arm_cpu: multi-cycle ARM data-processing execution core, one instruction per
// reset-initiated run (LOAD -> EXEC -> WB -> DONE).
//   clk          in  1   rising-edge clock
//   rst_n        in  1   asynchronous reset, ACTIVE-HIGH despite the name
//   instr        in  32  data-processing encoding, stable for the run
//   waiting      out 1   run complete, core idle
//   status_out   out 32  {N,Z,C,V,28'b0}
//   datapath_out out 32  registered ALU result
// Optional feature macro: COND_EXEC_EN (evaluate cond field in EXEC).
module arm_cpu
    import arm_cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    output logic        waiting,
    output logic [31:0] status_out,
    output logic [31:0] datapath_out
);

    state_e      state, state_next;
    logic [31:0] ir;
    logic [31:0] op_a, op_m;
    logic [7:0]  op_s;
    logic [31:0] rf [16];
    logic [31:0] status_q;
    logic [3:0]  flags_pend;
    logic        wr_rd_q, wr_flags_q;

    opcode_e     op;
    logic [31:0] op2_val, alu_res, x, y;
    logic [32:0] sum;
    logic        c_in, add_mode, sub_mode, carry, ovf, arith, cond_pass;
    logic [3:0]  alu_flags;

    assign op = opcode_e'(ir[24:21]);

    arm_shifter u_shifter (
        .imm    (ir[25]),
        .op2    (ir[11:0]),
        .rm     (op_m),
        .rs     (op_s),
        .result (op2_val)
    );

`ifdef COND_EXEC_EN
    logic f_n, f_z, f_c, f_v;
    assign f_n = status_q[FLAG_N];
    assign f_z = status_q[FLAG_Z];
    assign f_c = status_q[FLAG_C];
    assign f_v = status_q[FLAG_V];

    always_comb begin
        cond_pass = 1'b0;
        case (ir[31:28])
            4'h0: cond_pass = f_z;
            4'h1: cond_pass = !f_z;
            4'h2: cond_pass = f_c;
            4'h3: cond_pass = !f_c;
            4'h4: cond_pass = f_n;
            4'h5: cond_pass = !f_n;
            4'h6: cond_pass = f_v;
            4'h7: cond_pass = !f_v;
            4'h8: cond_pass = f_c && !f_z;
            4'h9: cond_pass = !f_c || f_z;
            4'hA: cond_pass = (f_n == f_v);
            4'hB: cond_pass = (f_n != f_v);
            4'hC: cond_pass = !f_z && (f_n == f_v);
            4'hD: cond_pass = f_z || (f_n != f_v);
            4'hE: cond_pass = 1'b1;
            4'hF: cond_pass = 1'b0;
        endcase
    end
`else
    logic unused_cond;
    assign cond_pass   = 1'b1;
    assign unused_cond = ^ir[31:28];
`endif

    logic unused_ir;
    assign unused_ir = ^ir[27:26];

    // ALU: subtract ops share one path with operands swapped for RSB/RSC;
    // C on subtract is the unsigned borrow (bit 32 of the 33-bit difference).
    always_comb begin
        c_in     = status_q[FLAG_C];
        alu_res  = '0;
        add_mode = 1'b0;
        sub_mode = 1'b0;
        x        = op_a;
        y        = op2_val;
        sum      = '0;
        carry    = 1'b0;
        ovf      = 1'b0;
        case (op)
            OP_AND, OP_TST: alu_res = op_a & op2_val;
            OP_EOR, OP_TEQ: alu_res = op_a ^ op2_val;
            OP_ORR:         alu_res = op_a | op2_val;
            OP_MOV:         alu_res = op2_val;
            OP_BIC:         alu_res = op_a & ~op2_val;
            OP_MVN:         alu_res = ~op2_val;
            OP_ADD, OP_CMN: add_mode = 1'b1;
            OP_ADC:         add_mode = 1'b1;
            OP_SUB, OP_CMP: sub_mode = 1'b1;
            OP_SBC:         sub_mode = 1'b1;
            OP_RSB, OP_RSC: begin
                sub_mode = 1'b1;
                x        = op2_val;
                y        = op_a;
            end
        endcase
        if (add_mode) begin
            sum     = {1'b0, x} + {1'b0, y} + {32'b0, (op == OP_ADC) && c_in};
            alu_res = sum[31:0];
            carry   = sum[32];
            ovf     = (x[31] == y[31]) && (sum[31] != x[31]);
        end else if (sub_mode) begin
            sum     = {1'b0, x} - {1'b0, y} - {32'b0, ((op == OP_SBC) || (op == OP_RSC)) && c_in};
            alu_res = sum[31:0];
            carry   = sum[32];
            ovf     = (x[31] != y[31]) && (sum[31] != x[31]);
        end
        arith     = add_mode || sub_mode;
        alu_flags = {alu_res[31], (alu_res == 32'd0),
                     arith ? carry : status_q[FLAG_C],
                     arith ? ovf   : status_q[FLAG_V]};
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_LOAD: state_next = ST_EXEC;
            ST_EXEC: state_next = ST_WB;
            ST_WB:   state_next = ST_DONE;
            ST_DONE: state_next = ST_DONE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) state <= ST_LOAD;
        else       state <= state_next;
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            ir           <= '0;
            op_a         <= '0;
            op_m         <= '0;
            op_s         <= '0;
            datapath_out <= '0;
            status_q     <= '0;
            flags_pend   <= '0;
            wr_rd_q      <= 1'b0;
            wr_flags_q   <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    ir   <= instr;
                    op_a <= rf[instr[19:16]];
                    op_m <= rf[instr[3:0]];
                    op_s <= rf[instr[11:8]][7:0];
                end
                ST_EXEC: begin
                    datapath_out <= alu_res;
                    flags_pend   <= alu_flags;
                    wr_rd_q      <= cond_pass && !is_compare(op);
                    wr_flags_q   <= cond_pass && (ir[20] || is_compare(op));
                end
                ST_WB: begin
                    if (wr_flags_q) status_q <= {flags_pend, 28'b0};
                end
                default: ;
            endcase
        end
    end

    // Register file is not reset; an async reset forces LOAD, so an aborted
    // run never reaches the WB write.
    always_ff @(posedge clk) begin
        if (state == ST_WB && wr_rd_q) rf[ir[15:12]] <= datapath_out;
    end

    assign waiting    = (state == ST_DONE);
    assign status_out = status_q;

endmodule

// File: tb/tb_arm_cpu.sv
// tb_arm_cpu: self-checking bench for arm_cpu with a behavioural reference
// model (register array + NZCV computed with wide integer arithmetic).
module tb_arm_cpu;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        waiting;
    logic [31:0] status_out;
    logic [31:0] datapath_out;

    int checks = 0;
    int errors = 0;

    logic [31:0] mregs [16];
    logic [3:0]  mflags;

    localparam longint MAXI = 64'sd2147483647;
    localparam longint MINI = -64'sd2147483648;

    arm_cpu dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr        (instr),
        .waiting      (waiting),
        .status_out   (status_out),
        .datapath_out (datapath_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] enc(input logic [3:0] cond, input logic i, input logic [3:0] opc,
                                        input logic s, input logic [3:0] rn, input logic [3:0] rd,
                                        input logic [11:0] op2);
        return {cond, 2'b00, i, opc, s, rn, rd, op2};
    endfunction

    function automatic logic [31:0] m_ror(input logic [31:0] v, input int unsigned amt);
        logic [63:0] d;
        d = {v, v} >> (amt % 32);
        return d[31:0];
    endfunction

    function automatic logic [31:0] m_op2(input logic [31:0] ins);
        logic [31:0] rm;
        logic [63:0] ext;
        int unsigned amt;
        if (ins[25]) return m_ror({24'b0, ins[7:0]}, 2 * ins[11:8]);
        rm  = mregs[ins[3:0]];
        amt = ins[4] ? int'(mregs[ins[11:8]][7:0]) : int'(ins[11:7]);
        if (amt == 0) return rm;
        case (ins[6:5])
            2'd0: return (amt >= 32) ? 32'd0 : (rm << amt);
            2'd1: return (amt >= 32) ? 32'd0 : (rm >> amt);
            2'd2: begin
                ext = {{32{rm[31]}}, rm};
                return (amt >= 32) ? {32{rm[31]}} : 32'(ext >> amt);
            end
            default: return m_ror(rm, amt);
        endcase
    endfunction

    // Executes one instruction on the model; flags start at zero because each
    // run is preceded by a reset.
    task automatic model_exec(input logic [31:0] ins, output logic [31:0] res, output logic [3:0] fl);
        int unsigned opc;
        logic [31:0] a, b;
        longint ua, ub, sa, sb, x, y, sx, sy, u, s, ci;
        bit arith, cf, vf, cmp;
        mflags = 4'b0;
        opc = ins[24:21];
        a = mregs[ins[19:16]];
        b = m_op2(ins);
        ua = longint'(a); ub = longint'(b);
        sa = longint'($signed(a)); sb = longint'($signed(b));
        arith = 0; cf = 0; vf = 0; res = 32'd0;
        cmp = (opc >= 8) && (opc <= 11);
        case (opc)
            0, 8:  res = a & b;
            1, 9:  res = a ^ b;
            12:    res = a | b;
            13:    res = b;
            14:    res = a & ~b;
            15:    res = ~b;
            4, 5, 11: begin
                arith = 1;
                ci = (opc == 5) ? longint'(mflags[1]) : 0;
                u = ua + ub + ci;
                s = sa + sb + ci;
                res = u[31:0];
                cf = (u > 64'hFFFF_FFFF);
                vf = (s > MAXI) || (s < MINI);
            end
            default: begin
                arith = 1;
                ci = (opc == 6 || opc == 7) ? longint'(mflags[1]) : 0;
                if (opc == 3 || opc == 7) begin
                    x = ub; y = ua; sx = sb; sy = sa;
                end else begin
                    x = ua; y = ub; sx = sa; sy = sb;
                end
                u = x - y - ci;
                s = sx - sy - ci;
                res = u[31:0];
                cf = (x < y + ci);
                vf = (s > MAXI) || (s < MINI);
            end
        endcase
        if (ins[20] || cmp)
            mflags = {res[31], (res == 32'd0), arith ? cf : mflags[1], arith ? vf : mflags[0]};
        if (!cmp) mregs[ins[15:12]] = res;
        fl = mflags;
    endtask

    // One reset-initiated run; returns outputs observed after edges 2 and 3.
    task automatic run_instr(input logic [31:0] ins, output logic [31:0] dp2, output logic w2,
                             output logic [31:0] dp3, output logic [31:0] st3, output logic w3);
        @(negedge clk);
        rst_n = 1'b1;
        instr = ins;
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        dp2 = datapath_out;
        w2  = waiting;
        @(posedge clk);
        @(negedge clk);
        dp3 = datapath_out;
        st3 = status_out;
        w3  = waiting;
        @(posedge clk);
    endtask

    task automatic test_reset;
        logic [31:0] dp2, dp3, st3, r;
        logic w2, w3;
        logic [3:0] fl;
        model_exec(enc(4'hE, 1'b1, 4'b1111, 1'b1, 4'h0, 4'h0, 12'h000), r, fl);
        run_instr(enc(4'hE, 1'b1, 4'b1111, 1'b1, 4'h0, 4'h0, 12'h000), dp2, w2, dp3, st3, w3);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (datapath_out !== 32'd0) begin
            errors++; $display("FAIL reset_datapath: got %h expected %h", datapath_out, 32'd0);
        end
        checks++;
        if (status_out !== 32'd0) begin
            errors++; $display("FAIL reset_status: got %h expected %h", status_out, 32'd0);
        end
        checks++;
        if (waiting !== 1'b0) begin
            errors++; $display("FAIL reset_waiting: got %b expected 0", waiting);
        end
    endtask

    task automatic test_preload;
        logic [31:0] ins, dp2, dp3, st3, r;
        logic w2, w3;
        logic [3:0] fl;
        for (int k = 0; k < 16; k++) begin
            ins = enc(4'hE, 1'b1, 4'b1101, 1'b0, 4'h0, 4'(k), {4'h0, 8'(k + 1)});
            model_exec(ins, r, fl);
            run_instr(ins, dp2, w2, dp3, st3, w3);
            checks++;
            if (dp2 !== 32'(k + 1) || dp3 !== 32'(k + 1)) begin
                errors++; $display("FAIL preload_r%0d: got %h/%h expected %h", k, dp2, dp3, 32'(k + 1));
            end
            checks++;
            if (st3 !== 32'd0 || w2 !== 1'b0 || w3 !== 1'b1) begin
                errors++; $display("FAIL preload_ctl_r%0d: got st=%h w2=%b w3=%b expected st=0 w2=0 w3=1", k, st3, w2, w3);
            end
        end
    endtask

    task automatic test_plan_sequence;
        logic [31:0] ins [14];
        logic [31:0] edp [14];
        logic [31:0] est [14];
        logic [31:0] dp2, dp3, st3, r;
        logic w2, w3;
        logic [3:0] fl;
        ins[0]  = enc(4'h0, 1'b0, 4'b0100, 1'b1, 4'h0, 4'h0, 12'h000); edp[0]  = 32'd2;  est[0]  = 32'h0;
        ins[1]  = enc(4'hE, 1'b0, 4'b0100, 1'b1, 4'h1, 4'h1, 12'h000); edp[1]  = 32'd4;  est[1]  = 32'h0;
        ins[2]  = enc(4'hE, 1'b1, 4'b0100, 1'b1, 4'h1, 4'h1, 12'h008); edp[2]  = 32'd12; est[2]  = 32'h0;
        ins[3]  = enc(4'hE, 1'b0, 4'b0100, 1'b1, 4'h2, 4'h2, 12'h210); edp[3]  = 32'd19; est[3]  = 32'h0;
        ins[4]  = enc(4'hE, 1'b0, 4'b0100, 1'b1, 4'h0, 4'h0, 12'h001); edp[4]  = 32'd14; est[4]  = 32'h0;
        ins[5]  = enc(4'hE, 1'b0, 4'b1010, 1'b1, 4'h0, 4'h0, 12'h001); edp[5]  = 32'd2;  est[5]  = 32'h0;
        ins[6]  = enc(4'hE, 1'b0, 4'b1101, 1'b0, 4'h0, 4'h0, 12'h000); edp[6]  = 32'd14; est[6]  = 32'h0;
        ins[7]  = enc(4'hE, 1'b0, 4'b0010, 1'b1, 4'h0, 4'h0, 12'h000); edp[7]  = 32'd0;  est[7]  = 32'h4000_0000;
        ins[8]  = enc(4'hE, 1'b0, 4'b0010, 1'b0, 4'h5, 4'h5, 12'h331); edp[8]  = 32'd6;  est[8]  = 32'h0;
        ins[9]  = enc(4'hE, 1'b1, 4'b1111, 1'b0, 4'h0, 4'h6, 12'h102); edp[9]  = 32'h7FFF_FFFF; est[9]  = 32'h0;
        ins[10] = enc(4'hE, 1'b1, 4'b0100, 1'b1, 4'h6, 4'h7, 12'h001); edp[10] = 32'h8000_0000; est[10] = 32'h9000_0000;
        ins[11] = enc(4'hE, 1'b1, 4'b1101, 1'b0, 4'h0, 4'h8, 12'h001); edp[11] = 32'd1;  est[11] = 32'h0;
        ins[12] = enc(4'hE, 1'b1, 4'b1101, 1'b0, 4'h0, 4'h9, 12'h002); edp[12] = 32'd2;  est[12] = 32'h0;
        ins[13] = enc(4'hE, 1'b0, 4'b1010, 1'b1, 4'h8, 4'h0, 12'h009); edp[13] = 32'hFFFF_FFFF; est[13] = 32'hA000_0000;
        for (int n = 0; n < 14; n++) begin
            model_exec(ins[n], r, fl);
            run_instr(ins[n], dp2, w2, dp3, st3, w3);
            checks++;
            if (dp2 !== edp[n] || dp3 !== edp[n]) begin
                errors++; $display("FAIL plan_%0d_datapath: got %h/%h expected %h", n, dp2, dp3, edp[n]);
            end
            checks++;
            if (st3 !== est[n] || w3 !== 1'b1) begin
                errors++; $display("FAIL plan_%0d_status: got %h w=%b expected %h w=1", n, st3, w3, est[n]);
            end
        end
    endtask

    task automatic test_abort;
        logic [31:0] ins, dp2, dp3, st3, r;
        logic w2, w3;
        logic [3:0] fl;
        for (int stage = 1; stage <= 2; stage++) begin
            ins = enc(4'hE, 1'b1, 4'b0100, 1'b1, 4'h3, 4'h3, 12'h0FF);
            @(negedge clk);
            rst_n = 1'b1;
            instr = ins;
            @(negedge clk);
            rst_n = 1'b0;
            repeat (stage) @(posedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            #1;
            checks++;
            if (datapath_out !== 32'd0 || waiting !== 1'b0 || status_out !== 32'd0) begin
                errors++; $display("FAIL abort_%0d_outputs: got dp=%h w=%b st=%h expected all 0", stage, datapath_out, waiting, status_out);
            end
            ins = enc(4'hE, 1'b0, 4'b1101, 1'b0, 4'h0, 4'h3, 12'h003);
            model_exec(ins, r, fl);
            run_instr(ins, dp2, w2, dp3, st3, w3);
            checks++;
            if (dp3 !== r || st3 !== 32'd0) begin
                errors++; $display("FAIL abort_%0d_r3: got %h st=%h expected %h st=0", stage, dp3, st3, r);
            end
        end
    endtask

    task automatic test_random;
        logic [31:0] ins, dp2, dp3, st3, r;
        logic w2, w3;
        logic [3:0] fl;
        for (int n = 0; n < 16; n++) begin
            ins = enc(4'hE, 1'b1, ($urandom % 2) ? 4'b1111 : 4'b1101, 1'b0, 4'h0, 4'(n), 12'($urandom));
            model_exec(ins, r, fl);
            run_instr(ins, dp2, w2, dp3, st3, w3);
        end
        for (int n = 0; n < 300; n++) begin
            ins = enc(4'hE, 1'($urandom), 4'($urandom), 1'($urandom), 4'($urandom), 4'($urandom), 12'($urandom));
            model_exec(ins, r, fl);
            run_instr(ins, dp2, w2, dp3, st3, w3);
            checks++;
            if (dp2 !== r || dp3 !== r) begin
                errors++; $display("FAIL random_%0d_datapath ins=%h: got %h/%h expected %h", n, ins, dp2, dp3, r);
            end
            checks++;
            if (st3 !== {fl, 28'b0} || w2 !== 1'b0 || w3 !== 1'b1) begin
                errors++; $display("FAIL random_%0d_status ins=%h: got %h w2=%b w3=%b expected %h w2=0 w3=1", n, ins, st3, w2, w3, {fl, 28'b0});
            end
        end
        for (int k = 0; k < 16; k++) begin
            ins = enc(4'hE, 1'b0, 4'b1101, 1'b0, 4'h0, 4'(k), {8'h00, 4'(k)});
            model_exec(ins, r, fl);
            run_instr(ins, dp2, w2, dp3, st3, w3);
            checks++;
            if (dp3 !== r) begin
                errors++; $display("FAIL regfile_r%0d: got %h expected %h", k, dp3, r);
            end
        end
    endtask

    initial begin
        rst_n = 1'b1;
        instr = 32'd0;
        mflags = 4'b0;
        for (int k = 0; k < 16; k++) mregs[k] = 32'd0;
        repeat (2) @(negedge clk);
        test_reset();
        test_preload();
        test_plan_sequence();
        test_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/arm_cpu.md
# arm_cpu

Multi-cycle execution core for the ARM-style data-processing subset of the 32-bit CPU. Executes one data-processing instruction per reset-initiated run against a 16×32 register file and a NZCV status register. Exposes the registered ALU result and flags for the surrounding system and bench. Branch, load/store and multiply are outside this block.

## Interface
- No parameters.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous reset, active-high (1 = reset) despite the name; starts a new instruction run.
- instr  in  32  ARM data-processing encoding; held stable for the whole run.
- waiting  out  1  high when the run is complete and the core is idle.
- status_out  out  32  {N,Z,C,V,28'b0}.
- datapath_out  out  32  registered ALU result of the current/last run.

## Operation
- Fields: cond[31:28], I[25], opcode[24:21], S[20], Rn[19:16], Rd[15:12]; operand2[11:0].
- Operand2 with I=1: imm8[7:0] rotated right by 2×rot[11:8].
- Operand2 with I=0, bit4=0: Rm[3:0] shifted by imm5[11:7]; type [6:5] is LSL/LSR/ASR/ROR; amount 0 means no shift (no RRX or #32 forms).
- Operand2 with I=0, bit4=1: Rm shifted by Rs[11:8] low byte. Amount ≥32: LSL/LSR → 0, ASR → sign fill, ROR uses amount mod 32.
- Opcodes: AND 0000, EOR 0001, SUB 0010, RSB 0011, ADD 0100, ADC 0101, SBC 0110 (A−B−C), RSC 0111, TST 1000, TEQ 1001, CMP 1010, CMN 1011, ORR 1100, MOV 1101 (Rn ignored), BIC 1110, MVN 1111.
- TST/TEQ/CMP/CMN never write Rd and always update flags. All other ops write Rd.
- Flags update when S=1 or on a compare op.
- N is result[31]; Z is (result==0).
- C for add ops is carry-out. C for subtract ops is borrow: 1 iff the minuend is less than the subtrahend (+C_in for SBC/RSC), unsigned.
- V for arithmetic ops is signed overflow. Logical ops leave C and V unchanged; the shifter carry is unused.
- Register file: R0–R15 all general purpose (no PC). Not cleared by reset; contents persist across runs.
- The status register is cleared by reset.

## Timing
- Reset (async) forces state LOAD, waiting=0, status_out=0, datapath_out=0, instruction register=0.
- LOAD: at the first rising edge after reset release, capture instr, read Rn/Rm/Rs into operand registers → EXEC.
- EXEC: shift + ALU, result registered to datapath_out, next flags computed → WB.
- WB: write Rd (if applicable), update status register → DONE.
- DONE: waiting=1; holds all outputs; remains until next reset.
- Result on datapath_out after 2 edges. Register/flags committed after 3 edges. Bench runs of 4 edges are valid.
- Reset mid-run aborts the run. If reset arrives before WB, no register or flag is written.
- When Rd equals a source register, the source value is the one read in LOAD.

## Configuration
- COND_EXEC_EN: when defined, cond is evaluated in EXEC against the current flags with standard ARM EQ…AL semantics (1111 treated as never). On failure, Rd and flags are not written, but datapath_out still updates.
- When COND_EXEC_EN is undefined (default build), cond is ignored and every instruction executes.

## Structure
- Package arm_cpu_pkg: opcode enum, shift-type enum, state enum (LOAD/EXEC/WB/DONE), flag bit positions (N=31, Z=30, C=29, V=28).
- One sub-module, arm_shifter: combinational operand2 barrel shifter/rotator.
- The ALU, register file and FSM live in arm_cpu.

## Test plan
- Preload Rk=k+1 via MOV Rk,#(k+1) runs (k=0..15) → each run datapath_out=k+1, status_out=0, waiting=1 after 3 edges.
- ADD R0,R0,R0 (cond 0000, S=1) → datapath_out=2, status 0. Then ADD R1,R1,R0 → 4. Then ADD R1,R1,#8 → 12.
- ADD R2,R2,R0 LSL R2 (R2=3, R0=2) → 19, status 0. Then ADD R0,R0,R1 → 14.
- CMP R0,R1 (14,12) → datapath_out=2, status 0, R0 unchanged. SUB R0,R0,R0 with S → 0, status 0x4000_0000.
- SUB R5,R5,R1 LSR R3 (6,12,4), S=0, after reset → 6, status 0 (reset cleared Z).
- Overflow/borrow: ADD with S of 0x7FFF_FFFF+1 → 0x8000_0000, status 0x9000_0000. CMP 1,2 → status 0xA000_0000. Reset asserted during EXEC → Rd unchanged.
